// File: rtl/y_mdu.sv
// y_mdu -- iterative RISC-V M-extension multiply/divide unit.
//
// One operation per accepted start. Multiplies use shift-add and divides use
// restoring division. Both run on operand magnitudes for WIDTH iterations. A
// final fix-up cycle applies the sign and selects the result. Latency is
// always WIDTH+1 cycles from the accepting edge to the done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled only while idle
//   op     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                  100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a, b   rs1 / rs2 operands
//   busy   operation in progress
//   done   one-cycle completion pulse
//   z      result, held until the next op completes
//   ex     divide-by-zero flag, held with z
//
// Configuration macro Y_MDU_DIV_EN:
//   defined   -> full unit with divider.
//   undefined -> the divider is not built. Divide ops still take WIDTH+1
//                cycles and return z=0, ex=1.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start, outputs hold the last result
// CALC  | one shift-add / trial-subtract iteration per cycle
// FIX   | sign correction, result select, done pulse

module y_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             ex
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [2:0]         op_r;
   logic               sgn;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc;
`ifdef Y_MDU_DIV_EN
   logic               dz;
`endif

   // Operand decode at the accepting edge.
   logic             a_sig;
   logic             b_sig;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             sgn_in;

   always_comb begin
      a_sig = ~op[0] | (op == 3'b001);
      b_sig = op[2] ? ~op[0] : ~op[1];
      a_mag = (a_sig & a[WIDTH-1]) ? -a : a;
      b_mag = (b_sig & b[WIDTH-1]) ? -b : b;
      sgn_in = 1'b0;
      case (op)
         3'b000, 3'b001, 3'b100: sgn_in = (a_sig & a[WIDTH-1]) ^ (b_sig & b[WIDTH-1]);
         3'b010, 3'b110:         sgn_in = a[WIDTH-1];
         default:                sgn_in = 1'b0;
      endcase
   end

   // One iteration. For multiply, acc = {partial product, remaining
   // multiplier bits}. For divide, acc = {remainder, dividend/quotient}.
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH:0]     sum;
`ifdef Y_MDU_DIV_EN
   logic [WIDTH:0]     r_sh;
   logic [WIDTH:0]     diff;
`endif

   always_comb begin
      sum = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd})
                   : {1'b0, acc[2*WIDTH-1:WIDTH]};
      acc_nxt = {sum, acc[WIDTH-1:1]};
`ifdef Y_MDU_DIV_EN
      r_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff = r_sh - {1'b0, opnd};
      if (op_r[2]) begin
         // A set top bit in diff is a borrow, so restore the shifted remainder.
         if (!diff[WIDTH])
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
`endif
   end

   // Fix-up: apply the sign and select the result.
   logic [2*WIDTH-1:0] prod_n;
   logic [WIDTH-1:0]   res;
   logic               ex_n;
`ifdef Y_MDU_DIV_EN
   logic [WIDTH-1:0]   quo_n;
   logic [WIDTH-1:0]   rem_n;
`endif

   always_comb begin
      prod_n = sgn ? -acc : acc;
`ifdef Y_MDU_DIV_EN
      quo_n = sgn ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_n = sgn ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      ex_n  = op_r[2] & dz;
`else
      ex_n  = op_r[2];
`endif
      res = '0;
      case (op_r)
         3'b000:                 res = prod_n[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: res = prod_n[2*WIDTH-1:WIDTH];
`ifdef Y_MDU_DIV_EN
         // With b=0 the divider yields quotient all ones and remainder |a|.
         // The sign fix already turns the remainder back into a. The
         // quotient needs an override so that it stays all ones.
         3'b100, 3'b101:         res = dz ? '1 : quo_n;
         3'b110, 3'b111:         res = rem_n;
`endif
         default:                res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_r  <= '0;
         sgn   <= 1'b0;
         opnd  <= '0;
         acc   <= '0;
`ifdef Y_MDU_DIV_EN
         dz    <= 1'b0;
`endif
         done  <= 1'b0;
         z     <= '0;
         ex    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_r  <= op;
                  sgn   <= sgn_in;
                  // The multiplier or the dividend goes in the low half of acc.
                  acc   <= {{WIDTH{1'b0}}, (op[2] ? a_mag : b_mag)};
                  opnd  <= op[2] ? b_mag : a_mag;
`ifdef Y_MDU_DIV_EN
                  dz    <= (b == '0);
`endif
                  cnt   <= '0;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST)
                  state <= S_FIX;
            end
            S_FIX: begin
               z     <= res;
               ex    <= ex_n;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_y_mdu.sv
// Self-checking bench for y_mdu (WIDTH=32). The reference model uses 64-bit
// integer arithmetic on the M-extension definitions. It follows whichever
// Y_MDU_DIV_EN build is compiled.

module tb_y_mdu;

   localparam int W = 32;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] z;
   logic         ex;

   int n_checks = 0;
   int n_fail   = 0;

   y_mdu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .z     (z),
      .ex    (ex)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 output logic [W-1:0] mz, output logic mex);
      longint          sa;
      longint          sb;
      longint          ua;
      longint          ub;
      longint          p;
      longint unsigned pu;
      sa  = longint'($signed(ma));
      sb  = longint'($signed(mb));
      ua  = longint'({32'b0, ma});
      ub  = longint'({32'b0, mb});
      mz  = '0;
      mex = 1'b0;
      case (mop)
         3'd0: begin p = sa * sb; mz = p[31:0]; end
         3'd1: begin p = sa * sb; mz = p[63:32]; end
         3'd2: begin p = sa * ub; mz = p[63:32]; end
         3'd3: begin pu = longint'(ua) * longint'(ub); mz = pu[63:32]; end
         default: begin
`ifdef Y_MDU_DIV_EN
            if (mb == 0) begin
               mex = 1'b1;
               mz  = (mop == 3'd4 || mop == 3'd5) ? {W{1'b1}} : ma;
            end else begin
               case (mop)
                  3'd4: begin p = sa / sb; mz = p[31:0]; end
                  3'd5: begin p = ua / ub; mz = p[31:0]; end
                  3'd6: begin p = sa % sb; mz = p[31:0]; end
                  default: begin p = ua % ub; mz = p[31:0]; end
               endcase
            end
`else
            mz  = '0;
            mex = 1'b1;
`endif
         end
      endcase
   endfunction

   // Runs one op starting at the current cycle, leaving time #1 after the
   // done edge. With poke set, start is pulsed 5 cycles into the op with junk.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input bit poke);
      logic [W-1:0] ez;
      logic         eex;
      logic [W-1:0] z_hold;
      bit           busy_ok;
      bit           z_ok;
      int           cyc;
      model(o, oa, ob, ez, eex);
      start = 1'b1;
      op    = o;
      a     = oa;
      b     = ob;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'($urandom);
      a     = $urandom;
      b     = $urandom;
      check("busy_after_accept", {63'b0, busy}, 64'd1);
      check("done_after_accept", {63'b0, done}, 64'd0);
      z_hold  = z;
      busy_ok = 1'b1;
      z_ok    = 1'b1;
      cyc     = 0;
      while (!done && cyc < 4 * LAT) begin
         start = (poke && cyc == 5);
         if (start) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (!done) begin
            if (!busy) busy_ok = 1'b0;
            if (z !== z_hold) z_ok = 1'b0;
         end
      end
      start = 1'b0;
      check("latency", 64'(cyc), 64'(LAT));
      check("busy_during_op", {63'b0, busy_ok}, 64'd1);
      check("z_held_during_op", {63'b0, z_ok}, 64'd1);
      check("busy_at_done", {63'b0, busy}, 64'd0);
      check($sformatf("z op=%0d a=%0h b=%0h", o, oa, ob), {32'b0, z}, {32'b0, ez});
      check($sformatf("ex op=%0d a=%0h b=%0h", o, oa, ob), {63'b0, ex}, {63'b0, eex});
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bit seen_done;
      rst   = 1'b1;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {63'b0, busy}, 64'd0);
      check("reset_done", {63'b0, done}, 64'd0);
      check("reset_z", {32'b0, z}, 64'd0);
      check("reset_ex", {63'b0, ex}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed cases; consecutive calls are back-to-back.
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(3'd5, 32'd100, 32'd7, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 1'b0);
      run_op(3'd5, 32'd5, 32'd0, 1'b0);
      run_op(3'd7, 32'd5, 32'd0, 1'b0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(3'd4, 32'd10, 32'd2, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b0);

      // Start pulses mid-op must be ignored.
      run_op(3'd0, 32'd12345, 32'd678, 1'b1);
      run_op(3'd6, 32'hDEAD_BEEF, 32'd97, 1'b1);

      // Random ops, with and without idle gaps.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         run_op(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 7) == 0));
      end

      // Abort a divide with reset after the last result left z nonzero.
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
      start = 1'b1;
      op    = 3'd4;
      a     = 32'd1000;
      b     = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", {63'b0, busy}, 64'd0);
      check("abort_done", {63'b0, done}, 64'd0);
      check("abort_z", {32'b0, z}, 64'd0);
      check("abort_ex", {63'b0, ex}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done = 1'b1;
      end
      check("no_done_after_abort", {63'b0, seen_done}, 64'd0);

      run_op(3'd4, 32'd10, 32'd2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
